data_sram_slave: RTL and testbench

- Responder end of the CPU data-side SRAM-like bus that the MEM stage drives as initiator.
- Accepts one request at a time, with a programmable address-accept delay and a programmable data-return latency.
- Performs byte-lane writes into an on-chip word RAM and returns full read words.
- Used as the data memory in core-level simulation and in the small FPGA build; replaced by the AXI bridge in the full SoC.

---
 rtl/cpu_bus_pkg.sv | 26 ++
 rtl/bram_be.sv | 36 +++
 rtl/data_sram_slave.sv | 112 +++++++++++
 tb/tb_data_sram_slave.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU SRAM-like bus responders: access sizes,
// handshake FSM states and the byte-lane strobe helper.
package cpu_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AWAIT = 2'd1,
    BUSY  = 2'd2
  } bus_state_t;

  // Size 2'b11 falls into the word case; misaligned half/word addresses are forced aligned.
  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << lo;
      SIZE_HALF: strb = 4'b0011 << {lo[1], 1'b0};
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/bram_be.sv
// Single-port word RAM with four byte enables and a registered read port that
// only loads on a read access, so the output holds between reads.
module bram_be #(
  parameter int    ADDR_W    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // The read register is cleared by reset; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_slave.sv
// Responder for the CPU data-side SRAM-like bus: one outstanding request,
// programmable address-accept delay and data-return latency, byte-lane writes.
module data_sram_slave
  import cpu_bus_pkg::*;
#(
  parameter int    ADDR_W     = 12,
  parameter int    ADDR_DELAY = 0,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam logic [3:0] DELAY_CNT = 4'(ADDR_DELAY);
  localparam logic [3:0] LAT_CNT   = 4'(LATENCY);

  bus_state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       handshake;
  logic       unused_addr;

  // Gating with rst keeps addr_ok low during reset, so no write can commit then.
  always_comb begin
    data_addr_ok = 1'b0;
    case (state_reg)
      IDLE:    data_addr_ok = (ADDR_DELAY == 0) && data_req;
      AWAIT:   data_addr_ok = data_req && (cnt_reg == DELAY_CNT);
      default: data_addr_ok = 1'b0;
    endcase
    if (rst) data_addr_ok = 1'b0;
  end

  assign handshake    = data_req && data_addr_ok;
  assign data_data_ok = (state_reg == BUSY) && (cnt_reg == LAT_CNT);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          state_next = BUSY;
          cnt_next   = 4'd1;
        end else if (data_req) begin
          state_next = AWAIT;
          cnt_next   = 4'd1;
        end
      end
      AWAIT: begin
        if (!data_req) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (handshake) begin
          state_next = BUSY;
          cnt_next   = 4'd1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      BUSY: begin
        if (cnt_reg == LAT_CNT) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The access commits at the handshake edge, so no request fields need holding in BUSY.
  bram_be #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .en   (handshake),
    .we   (data_wr),
    .be   (byte_strobe(data_size, data_addr[1:0])),
    .addr (data_addr[ADDR_W+1:2]),
    .wdata(data_wdata),
    .rdata(data_rdata)
  );

  // Upper address bits alias onto the RAM.
  assign unused_addr = ^data_addr[31:ADDR_W+2];

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench: default-timing instance plus an ADDR_DELAY=2 / LATENCY=3 instance.
module tb_data_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters
  logic        a_rst, a_req, a_wr;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_aok, a_dok;

  data_sram_slave u_dut_a (
    .clk(clk), .rst(a_rst), .data_req(a_req), .data_wr(a_wr), .data_size(a_size),
    .data_addr(a_addr), .data_wdata(a_wdata), .data_addr_ok(a_aok),
    .data_data_ok(a_dok), .data_rdata(a_rdata)
  );

  // Instance B: slow timing
  logic        b_rst, b_req, b_wr;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_aok, b_dok;

  data_sram_slave #(.ADDR_W(12), .ADDR_DELAY(2), .LATENCY(3)) u_dut_b (
    .clk(clk), .rst(b_rst), .data_req(b_req), .data_wr(b_wr), .data_size(b_size),
    .data_addr(b_addr), .data_wdata(b_wdata), .data_addr_ok(b_aok),
    .data_data_ok(b_dok), .data_rdata(b_rdata)
  );

  logic [31:0] a_last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One bus cycle: drive after the falling edge, outputs readable on return.
  task automatic step_a(input logic rst_i, input logic req, input logic wr,
                        input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    a_rst = rst_i; a_req = req; a_wr = wr; a_size = size; a_addr = addr; a_wdata = wdata;
    #1;
  endtask

  task automatic step_b(input logic rst_i, input logic req, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    b_rst = rst_i; b_req = req; b_wr = wr; b_size = 2'b10; b_addr = addr; b_wdata = wdata;
    #1;
  endtask

  // Default timing: accepted in the request cycle, data_ok one cycle later.
  task automatic txn_a(input string tag, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd);
    step_a(1'b0, 1'b1, wr, size, addr, wdata);
    check({tag, " addr_ok"}, 32'(a_aok), 32'd1);
    check({tag, " data_ok early"}, 32'(a_dok), 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
    check({tag, " data_ok"}, 32'(a_dok), 32'd1);
    check({tag, " addr_ok busy"}, 32'(a_aok), 32'd0);
    if (!wr) a_last_rd = exp_rd;
    check({tag, " rdata"}, a_rdata, a_last_rd);
  endtask

  // Slow timing: accept at cycle 2, data_ok at cycle 5.
  task automatic txn_b(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd);
    for (int c = 0; c <= 5; c++) begin
      step_b(1'b0, c <= 2, wr, addr, wdata);
      check($sformatf("%s c%0d addr_ok", tag, c), 32'(b_aok), 32'(c == 2));
      check($sformatf("%s c%0d data_ok", tag, c), 32'(b_dok), 32'(c == 5));
      if (c == 5 && !wr) check({tag, " rdata"}, b_rdata, exp_rd);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_req = 1'b0; a_wr = 1'b0; a_size = 2'b10; a_addr = '0; a_wdata = '0;
    b_rst = 1'b1; b_req = 1'b0; b_wr = 1'b0; b_size = 2'b10; b_addr = '0; b_wdata = '0;
    a_last_rd = 32'd0;

    // Reset state
    step_a(1'b1, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
    step_a(1'b1, 1'b1, 1'b0, 2'b10, 32'd0, 32'd0);
    check("A addr_ok in reset", 32'(a_aok), 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
    check("A reset addr_ok", 32'(a_aok), 32'd0);
    check("A reset data_ok", 32'(a_dok), 32'd0);
    check("A reset rdata", a_rdata, 32'd0);

    // Word write/read
    txn_a("A wr 0x100", 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 32'd0);
    txn_a("A rd 0x100", 1'b0, 2'b10, 32'h100, 32'd0, 32'hDEADBEEF);

    // Byte and half lanes; the write data_ok cycles also check rdata holds
    txn_a("A wr 0x200", 1'b1, 2'b10, 32'h200, 32'h11223344, 32'd0);
    txn_a("A wb 0x201", 1'b1, 2'b00, 32'h201, 32'hAAAAAAAA, 32'd0);
    txn_a("A wh 0x202", 1'b1, 2'b01, 32'h202, 32'h55665566, 32'd0);
    txn_a("A rd 0x200", 1'b0, 2'b10, 32'h200, 32'd0, 32'h5566AA44);

    // Size 11 and misaligned word are full aligned words
    txn_a("A w11 0x503", 1'b1, 2'b11, 32'h503, 32'h01020304, 32'd0);
    txn_a("A rd 0x500", 1'b0, 2'b10, 32'h500, 32'd0, 32'h01020304);

    // Aliasing of upper address bits
    txn_a("A wr 0x4008", 1'b1, 2'b10, 32'h00004008, 32'h0F0F1234, 32'd0);
    txn_a("A rd 0x0008", 1'b0, 2'b10, 32'h00000008, 32'd0, 32'h0F0F1234);

    // Back-to-back reads, request held through the data_ok cycle
    txn_a("A wr 0x0", 1'b1, 2'b10, 32'h0, 32'hA0A0A0A0, 32'd0);
    txn_a("A wr 0x4", 1'b1, 2'b10, 32'h4, 32'hB4B4B4B4, 32'd0);
    step_a(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'd0);
    check("A b2b first addr_ok", 32'(a_aok), 32'd1);
    step_a(1'b0, 1'b1, 1'b0, 2'b10, 32'h4, 32'd0);
    check("A b2b first data_ok", 32'(a_dok), 32'd1);
    check("A b2b no addr_ok with data_ok", 32'(a_aok), 32'd0);
    check("A b2b first rdata", a_rdata, 32'hA0A0A0A0);
    step_a(1'b0, 1'b1, 1'b0, 2'b10, 32'h4, 32'd0);
    check("A b2b second addr_ok", 32'(a_aok), 32'd1);
    check("A b2b idle data_ok", 32'(a_dok), 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'd0);
    check("A b2b second data_ok", 32'(a_dok), 32'd1);
    check("A b2b second rdata", a_rdata, 32'hB4B4B4B4);
    a_last_rd = 32'hB4B4B4B4;

    // A write attempted while rst is high must not commit
    txn_a("A wr 0x300", 1'b1, 2'b10, 32'h300, 32'hCAFEF00D, 32'd0);
    step_a(1'b1, 1'b1, 1'b1, 2'b10, 32'h300, 32'h0BADBAD0);
    check("A rst-cycle addr_ok", 32'(a_aok), 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
    check("A post-rst rdata", a_rdata, 32'd0);
    a_last_rd = 32'd0;
    txn_a("A rd 0x300", 1'b0, 2'b10, 32'h300, 32'd0, 32'hCAFEF00D);

    // Instance B: delayed accept and longer latency
    step_b(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("B reset data_ok", 32'(b_dok), 32'd0);
    txn_b("B wr 0x40", 1'b1, 32'h40, 32'h77665544, 32'd0);
    txn_b("B rd 0x40", 1'b0, 32'h40, 32'd0, 32'h77665544);

    // Request withdrawn during the accept delay
    for (int c = 0; c < 4; c++) begin
      step_b(1'b0, c == 0, 1'b0, 32'h40, 32'd0);
      check($sformatf("B drop c%0d addr_ok", c), 32'(b_aok), 32'd0);
    end
    txn_b("B rd after drop", 1'b0, 32'h40, 32'd0, 32'h77665544);

    // Reset at accept+2 drops the read
    for (int c = 0; c <= 4; c++) begin
      step_b(c == 4, c <= 2, 1'b0, 32'h40, 32'd0);
      check($sformatf("B rstbusy c%0d addr_ok", c), 32'(b_aok), 32'(c == 2));
      check($sformatf("B rstbusy c%0d data_ok", c), 32'(b_dok), 32'd0);
    end
    step_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("B post-rst addr_ok", 32'(b_aok), 32'd0);
    check("B post-rst rdata", b_rdata, 32'd0);
    for (int c = 0; c < 6; c++) begin
      step_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check($sformatf("B post-rst c%0d data_ok", c), 32'(b_dok), 32'd0);
    end
    txn_b("B rd kept", 1'b0, 32'h40, 32'd0, 32'h77665544);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
